// File: rtl/disp_axi4_burst_slave.sv
// ---------------------------------------------------------------------------
// disp_axi4_burst_slave
//
// AXI4 burst responder backing the display framebuffer/register window.
// It handles one transaction at a time, either a write burst or a read burst,
// of FIXED, INCR or WRAP type. Data lives in a MEM_WORDS x 32-bit word array.
//
// Ports:
//   ACLK, ARESET             clock (rising edge), synchronous active-high reset
//   S_AXI_AW*                write address channel (ID, address, len, size, burst)
//   S_AXI_W*                 write data channel (data, byte strobes, last)
//   S_AXI_B*                 write response channel (ID, response)
//   S_AXI_AR*                read address channel (ID, address, len, size, burst)
//   S_AXI_R*                 read data channel (ID, data, response, last)
//
// Optional build macro DISP_AXI_SLVERR_EN:
//   When it is defined, beats whose address lies beyond the window are out of
//   range. Such write beats are dropped and the burst gets SLVERR. Such read
//   beats return zero data with SLVERR. When it is not defined, upper address
//   bits alias onto the array.
// ---------------------------------------------------------------------------
module disp_axi4_burst_slave #(
  parameter int ID_W      = 4,
  parameter int MEM_WORDS = 64,
  parameter int ADDR_W    = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   S_AXI_AWID,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic [7:0]        S_AXI_AWLEN,
  input  logic [2:0]        S_AXI_AWSIZE,
  input  logic [1:0]        S_AXI_AWBURST,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WLAST,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [ID_W-1:0]   S_AXI_BID,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ID_W-1:0]   S_AXI_ARID,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic [7:0]        S_AXI_ARLEN,
  input  logic [2:0]        S_AXI_ARSIZE,
  input  logic [1:0]        S_AXI_ARBURST,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [ID_W-1:0]   S_AXI_RID,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RLAST,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WBURST, WRESP, RBURST} state_e;

  state_e            state_q, state_d;
  logic [31:0]       mem_q [MEM_WORDS];
  logic [ID_W-1:0]   id_q, bid_q, rid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q, cnt_q;
  logic [1:0]        burst_q, bresp_q, rresp_q;
  logic              werr_q, rvalid_q, rlast_q;
  logic [31:0]       rdata_q;

  logic              awReady, arReady, wReady, bValid;
  logic              awHs, arHs, wHs, bHs, rHs, lastBeat;
  logic              wrOor, rdOor, beatErr;
  logic [ADDR_W-1:0] rdAddr;
  logic              unusedOk;

  // Address of the following beat. WRAP folds the incremented address back
  // into the (len+1)*4 byte aligned window; (len+1)*4-1 is simply {len,2'b11}.
  // WRAP with an unsupported length and burst type 11 both behave as INCR.
  function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] a,
                                                 input logic [7:0] len,
                                                 input logic [1:0] burst);
    logic [ADDR_W-1:0] inc, mask;
    inc      = a + ADDR_W'(4);
    mask     = ADDR_W'({len, 2'b11});
    nextAddr = inc;
    if (burst == 2'b00) begin
      nextAddr = a;
    end else if (burst == 2'b10 &&
                 (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      nextAddr = (a & ~mask) | (inc & mask);
    end
  endfunction

  function automatic logic [IDX_W-1:0] wordIdx(input logic [ADDR_W-1:0] a);
    wordIdx = a[2 +: IDX_W];
  endfunction

  // Readies and BVALID depend only on state, apart from ARREADY yielding to a
  // write that is being offered in the same cycle.
  assign awReady  = !ARESET && state_q == IDLE;
  assign arReady  = !ARESET && state_q == IDLE && !S_AXI_AWVALID;
  assign wReady   = !ARESET && state_q == WBURST;
  assign bValid   = !ARESET && state_q == WRESP;
  assign awHs     = S_AXI_AWVALID && awReady;
  assign arHs     = S_AXI_ARVALID && arReady;
  assign wHs      = S_AXI_WVALID && wReady;
  assign bHs      = bValid && S_AXI_BREADY;
  assign rHs      = rvalid_q && S_AXI_RREADY;
  assign lastBeat = cnt_q == len_q;

  // The read beat being fetched is the AR address itself when the burst
  // starts, otherwise the already-advanced burst address.
  assign rdAddr = (state_q == IDLE) ? {S_AXI_ARADDR[ADDR_W-1:2], 2'b00} : addr_q;

`ifdef DISP_AXI_SLVERR_EN
  assign wrOor = |addr_q[ADDR_W-1:IDX_W+2];
  assign rdOor = |rdAddr[ADDR_W-1:IDX_W+2];
`else
  assign wrOor = 1'b0;
  assign rdOor = 1'b0;
`endif

  assign beatErr  = (S_AXI_WLAST != lastBeat) || wrOor;
  assign unusedOk = ^{S_AXI_AWSIZE, S_AXI_ARSIZE, S_AXI_AWADDR[1:0], rdAddr};

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: write bursts end on the beat counter, not on WLAST.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (awHs) state_d = WBURST;
               else if (arHs) state_d = RBURST;
      WBURST:  if (wHs && lastBeat) state_d = WRESP;
      WRESP:   if (bHs) state_d = IDLE;
      RBURST:  if (rHs && rlast_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst bookkeeping and registered response channels. Read data is fetched
  // one beat ahead so RDATA is a register that holds while the master stalls.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      burst_q  <= '0;
      werr_q   <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= '0;
      rid_q    <= '0;
      rresp_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (awHs) begin
            id_q    <= S_AXI_AWID;
            addr_q  <= {S_AXI_AWADDR[ADDR_W-1:2], 2'b00};
            len_q   <= S_AXI_AWLEN;
            burst_q <= S_AXI_AWBURST;
            cnt_q   <= '0;
            werr_q  <= 1'b0;
          end else if (arHs) begin
            rid_q    <= S_AXI_ARID;
            len_q    <= S_AXI_ARLEN;
            burst_q  <= S_AXI_ARBURST;
            cnt_q    <= '0;
            addr_q   <= nextAddr(rdAddr, S_AXI_ARLEN, S_AXI_ARBURST);
            rdata_q  <= rdOor ? 32'd0 : mem_q[wordIdx(rdAddr)];
            rresp_q  <= rdOor ? 2'b10 : 2'b00;
            rvalid_q <= 1'b1;
            rlast_q  <= S_AXI_ARLEN == 8'd0;
          end
        end
        WBURST: begin
          if (wHs) begin
            addr_q <= nextAddr(addr_q, len_q, burst_q);
            cnt_q  <= cnt_q + 8'd1;
            werr_q <= werr_q || beatErr;
            if (lastBeat) begin
              bid_q   <= id_q;
              bresp_q <= (werr_q || beatErr) ? 2'b10 : 2'b00;
            end
          end
        end
        RBURST: begin
          if (rHs) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
            end else begin
              addr_q  <= nextAddr(addr_q, len_q, burst_q);
              cnt_q   <= cnt_q + 8'd1;
              rdata_q <= rdOor ? 32'd0 : mem_q[wordIdx(rdAddr)];
              rresp_q <= rdOor ? 2'b10 : 2'b00;
              rlast_q <= (cnt_q + 8'd1) == len_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Byte-enabled array write; contents survive reset.
  always_ff @(posedge ACLK) begin
    if (wHs && !wrOor) begin
      for (int b = 0; b < 4; b++) begin
        if (S_AXI_WSTRB[b]) mem_q[wordIdx(addr_q)][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  assign S_AXI_AWREADY = awReady;
  assign S_AXI_ARREADY = arReady;
  assign S_AXI_WREADY  = wReady;
  assign S_AXI_BVALID  = bValid;
  assign S_AXI_BID     = bid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RVALID  = rvalid_q;

endmodule

// File: tb/tb_disp_axi4_burst_slave.sv
// ---------------------------------------------------------------------------
// tb_disp_axi4_burst_slave
//
// Directed bench for disp_axi4_burst_slave. Stimulus tasks push the expected
// B and R responses into queues; a monitor pops and compares them whenever a
// response handshake is seen, and also checks that stalled read data holds.
// ---------------------------------------------------------------------------
module tb_disp_axi4_burst_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  S_AXI_AWID, S_AXI_ARID, S_AXI_BID, S_AXI_RID;
  logic [31:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic [7:0]  S_AXI_AWLEN, S_AXI_ARLEN;
  logic [2:0]  S_AXI_AWSIZE, S_AXI_ARSIZE;
  logic [1:0]  S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
  logic        S_AXI_BVALID, S_AXI_BREADY;
  logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;

  typedef struct packed {logic [1:0] resp; logic [3:0] id;} bExp_t;
  typedef struct packed {logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id;} rExp_t;

  bExp_t       bQ[$];
  rExp_t       rQ[$];
  int          checks = 0;
  int          errors = 0;
  int          bSeen = 0;
  int          rSeen = 0;
  int          arHsB = 0;
  logic [31:0] wd[16];
  logic [3:0]  ws[16];
  logic        rrPat[4];
  int          rrLen;

  disp_axi4_burst_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  // 100 MHz clock.
  always #5 ACLK = ~ACLK;

  // Safety net in case a handshake never completes despite the bounded loops.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic pushB(input logic [1:0] resp, input logic [3:0] id);
    bExp_t e;
    e.resp = resp;
    e.id   = id;
    bQ.push_back(e);
  endtask

  task automatic pushR(input logic [31:0] data, input logic [1:0] resp, input logic last,
                       input logic [3:0] id);
    rExp_t e;
    e.data = data;
    e.resp = resp;
    e.last = last;
    e.id   = id;
    rQ.push_back(e);
  endtask

  // Response monitor: samples on the falling edge, ahead of the rising edge
  // where the handshake completes.
  task automatic monitorLoop();
    bExp_t be;
    rExp_t re;
    forever begin
      @(negedge ACLK);
      if (!ARESET) begin
        if (S_AXI_BVALID && S_AXI_BREADY) begin
          if (bQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL bUnexpected: actual=B beat bresp=%h required=no beat", S_AXI_BRESP);
          end else begin
            be = bQ.pop_front();
            checkOutput("bresp", {30'd0, S_AXI_BRESP}, {30'd0, be.resp});
            checkOutput("bid", {28'd0, S_AXI_BID}, {28'd0, be.id});
          end
          bSeen++;
        end
        if (S_AXI_RVALID && S_AXI_RREADY) begin
          if (rQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL rUnexpected: actual=R beat rdata=%h required=no beat", S_AXI_RDATA);
          end else begin
            re = rQ.pop_front();
            checkOutput("rdata", S_AXI_RDATA, re.data);
            checkOutput("rresp", {30'd0, S_AXI_RRESP}, {30'd0, re.resp});
            checkOutput("rlast", {31'd0, S_AXI_RLAST}, {31'd0, re.last});
            checkOutput("rid", {28'd0, S_AXI_RID}, {28'd0, re.id});
          end
          rSeen++;
        end else if (S_AXI_RVALID && rQ.size() > 0) begin
          checkOutput("rdataStall", S_AXI_RDATA, rQ[0].data);
        end
      end
    end
  endtask

  // Issue one write burst from wd/ws. WLAST is raised on beat lastAt; bHold
  // keeps BREADY low for that many cycles after the final W beat.
  task automatic applyWriteStimulus(input logic [3:0] id, input logic [31:0] addr,
                                    input logic [7:0] len, input logic [1:0] burst,
                                    input int lastAt, input int bHold);
    bit hs;
    int target;
    target        = bSeen + 1;
    S_AXI_AWID    = id;
    S_AXI_AWADDR  = addr;
    S_AXI_AWLEN   = len;
    S_AXI_AWSIZE  = 3'b010;
    S_AXI_AWBURST = burst;
    S_AXI_AWVALID = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge ACLK);
      hs = S_AXI_AWREADY;
      @(posedge ACLK);
      #1;
    end
    S_AXI_AWVALID = 1'b0;
    checkOutput("awHandshake", {31'd0, hs}, 32'd1);
    S_AXI_BREADY = (bHold == 0);
    for (int b = 0; b <= int'(len); b++) begin
      S_AXI_WDATA  = wd[b];
      S_AXI_WSTRB  = ws[b];
      S_AXI_WLAST  = (b == lastAt);
      S_AXI_WVALID = 1'b1;
      hs = 1'b0;
      for (int c = 0; c < 50 && !hs; c++) begin
        @(negedge ACLK);
        hs = S_AXI_WREADY;
        @(posedge ACLK);
        #1;
      end
      checkOutput("wHandshake", {31'd0, hs}, 32'd1);
    end
    S_AXI_WVALID = 1'b0;
    S_AXI_WLAST  = 1'b0;
    if (bHold > 0) begin
      for (int i = 0; i < bHold; i++) begin
        @(negedge ACLK);
        checkOutput("bvalidHeld", {31'd0, S_AXI_BVALID}, 32'd1);
      end
      @(posedge ACLK);
      #1;
      S_AXI_BREADY = 1'b1;
    end
    for (int c = 0; c < 100 && bSeen < target; c++) begin
      @(posedge ACLK);
      #1;
    end
    checkOutput("bDone", {31'd0, bSeen >= target}, 32'd1);
  endtask

  // Issue one read burst; RREADY follows rrPat cyclically from the AR handshake.
  task automatic applyReadStimulus(input logic [3:0] id, input logic [31:0] addr,
                                   input logic [7:0] len, input logic [1:0] burst);
    bit hs;
    int target;
    int k;
    target        = rSeen + int'(len) + 1;
    S_AXI_ARID    = id;
    S_AXI_ARADDR  = addr;
    S_AXI_ARLEN   = len;
    S_AXI_ARSIZE  = 3'b010;
    S_AXI_ARBURST = burst;
    S_AXI_ARVALID = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge ACLK);
      hs = S_AXI_ARREADY;
      @(posedge ACLK);
      #1;
    end
    S_AXI_ARVALID = 1'b0;
    arHsB = bSeen;
    checkOutput("arHandshake", {31'd0, hs}, 32'd1);
    k = 0;
    S_AXI_RREADY = rrPat[0];
    for (int c = 0; c < 300 && rSeen < target; c++) begin
      @(posedge ACLK);
      #1;
      k++;
      S_AXI_RREADY = rrPat[k % rrLen];
    end
    S_AXI_RREADY = 1'b1;
    checkOutput("rDone", {31'd0, rSeen >= target}, 32'd1);
  endtask

  initial begin
    int  bBefore;
    bit  hs;
    ARESET        = 1'b1;
    S_AXI_AWID    = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = 3'b010;
    S_AXI_AWBURST = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY  = 1'b1;
    S_AXI_ARID    = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = 3'b010;
    S_AXI_ARBURST = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b1;
    rrPat = '{1'b1, 1'b1, 1'b1, 1'b1};
    rrLen = 1;
    for (int i = 0; i < 16; i++) ws[i] = 4'hF;

    fork
      monitorLoop();
    join_none

    // Reset state.
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("rstAwready", {31'd0, S_AXI_AWREADY}, 32'd0);
    checkOutput("rstArready", {31'd0, S_AXI_ARREADY}, 32'd0);
    checkOutput("rstWready", {31'd0, S_AXI_WREADY}, 32'd0);
    checkOutput("rstBvalid", {31'd0, S_AXI_BVALID}, 32'd0);
    checkOutput("rstRvalid", {31'd0, S_AXI_RVALID}, 32'd0);
    checkOutput("rstRlast", {31'd0, S_AXI_RLAST}, 32'd0);
    checkOutput("rstRdata", S_AXI_RDATA, 32'd0);
    checkOutput("rstBresp", {30'd0, S_AXI_BRESP}, 32'd0);
    checkOutput("rstRresp", {30'd0, S_AXI_RRESP}, 32'd0);
    checkOutput("rstBid", {28'd0, S_AXI_BID}, 32'd0);
    checkOutput("rstRid", {28'd0, S_AXI_RID}, 32'd0);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;

    // 16-beat INCR write from 0x00, then 16-beat WRAP read from 0x00.
    $display("[TB] INCR write / WRAP read, 16 beats");
    for (int i = 0; i < 16; i++) wd[i] = {8'(i * 17), 24'h13579B};
    wd[0]  = 32'hFFFF_FFFF;
    wd[15] = 32'h00AB_CDEF;
    pushB(2'b00, 4'd3);
    applyWriteStimulus(4'd3, 32'h00, 8'd15, 2'b01, 15, 0);
    for (int i = 0; i < 16; i++) pushR(wd[i], 2'b00, i == 15, 4'd5);
    applyReadStimulus(4'd5, 32'h00, 8'd15, 2'b10);

    // 4-beat WRAP read starting mid-window at 0x08.
    $display("[TB] WRAP read, 4 beats from 0x08");
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
    pushB(2'b00, 4'd4);
    applyWriteStimulus(4'd4, 32'h00, 8'd3, 2'b01, 3, 0);
    pushR(32'hC, 2'b00, 1'b0, 4'd6);
    pushR(32'hD, 2'b00, 1'b0, 4'd6);
    pushR(32'hA, 2'b00, 1'b0, 4'd6);
    pushR(32'hB, 2'b00, 1'b1, 4'd6);
    applyReadStimulus(4'd6, 32'h08, 8'd3, 2'b10);

    // FIXED write to word 4 with a partial strobe on the final beat.
    $display("[TB] FIXED write with partial strobe");
    wd[0] = 32'h0001_0001; wd[1] = 32'h0002_0002; wd[2] = 32'h0003_0003; wd[3] = 32'h0004_0004;
    ws[3] = 4'b0011;
    pushB(2'b00, 4'd7);
    applyWriteStimulus(4'd7, 32'h10, 8'd3, 2'b00, 3, 0);
    ws[3] = 4'hF;
    pushR(32'h0003_0004, 2'b00, 1'b1, 4'd8);
    applyReadStimulus(4'd8, 32'h10, 8'd0, 2'b01);

    // AW and AR offered together: the write must finish before AR is taken.
    $display("[TB] simultaneous AW and AR");
    wd[0] = 32'hCAFE_F00D;
    pushB(2'b00, 4'd1);
    pushR(32'hCAFE_F00D, 2'b00, 1'b1, 4'd2);
    bBefore = bSeen;
    fork
      applyWriteStimulus(4'd1, 32'h20, 8'd0, 2'b01, 0, 0);
      applyReadStimulus(4'd2, 32'h20, 8'd0, 2'b01);
      begin
        @(negedge ACLK);
        checkOutput("arreadyYield", {31'd0, S_AXI_ARREADY}, 32'd0);
      end
    join
    checkOutput("arAfterB", arHsB, bBefore + 1);

    // RREADY stalls during a 4-beat INCR read of words 0..3.
    $display("[TB] RREADY stalls");
    rrPat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rrLen = 4;
    pushR(32'hA, 2'b00, 1'b0, 4'd3);
    pushR(32'hB, 2'b00, 1'b0, 4'd3);
    pushR(32'hC, 2'b00, 1'b0, 4'd3);
    pushR(32'hD, 2'b00, 1'b1, 4'd3);
    applyReadStimulus(4'd3, 32'h00, 8'd3, 2'b01);
    rrLen = 1;

    // BREADY held low for 5 cycles.
    $display("[TB] BREADY back-pressure");
    wd[0] = 32'h0BAD_BEEF;
    pushB(2'b00, 4'd9);
    applyWriteStimulus(4'd9, 32'h30, 8'd0, 2'b01, 0, 5);

    // Early WLAST: all 4 beats still land, response is SLVERR.
    $display("[TB] early WLAST");
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    pushB(2'b10, 4'hA);
    applyWriteStimulus(4'hA, 32'h40, 8'd3, 2'b01, 2, 0);
    pushR(32'h11, 2'b00, 1'b0, 4'hB);
    pushR(32'h22, 2'b00, 1'b0, 4'hB);
    pushR(32'h33, 2'b00, 1'b0, 4'hB);
    pushR(32'h44, 2'b00, 1'b1, 4'hB);
    applyReadStimulus(4'hB, 32'h40, 8'd3, 2'b01);

    // Reset in the middle of a stalled read: the burst is abandoned.
    $display("[TB] reset mid-read");
    S_AXI_RREADY  = 1'b0;
    S_AXI_ARID    = 4'h5;
    S_AXI_ARADDR  = 32'h00;
    S_AXI_ARLEN   = 8'd7;
    S_AXI_ARBURST = 2'b01;
    S_AXI_ARVALID = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge ACLK);
      hs = S_AXI_ARREADY;
      @(posedge ACLK);
      #1;
    end
    S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    checkOutput("rvalidBeforeAbort", {31'd0, S_AXI_RVALID}, 32'd1);
    @(posedge ACLK);
    #1;
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    checkOutput("rvalidAfterReset", {31'd0, S_AXI_RVALID}, 32'd0);
    S_AXI_RREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      checkOutput("noBeatAfterAbort", {31'd0, S_AXI_RVALID}, 32'd0);
    end
    @(posedge ACLK);
    #1;

    // A fresh transaction after the abort behaves normally.
    wd[0] = 32'h5555_AAAA; wd[1] = 32'h1234_5678;
    pushB(2'b00, 4'hC);
    applyWriteStimulus(4'hC, 32'h50, 8'd1, 2'b01, 1, 0);
    pushR(32'h5555_AAAA, 2'b00, 1'b0, 4'hD);
    pushR(32'h1234_5678, 2'b00, 1'b1, 4'hD);
    applyReadStimulus(4'hD, 32'h50, 8'd1, 2'b01);

    checkOutput("bQueueDrained", bQ.size(), 32'd0);
    checkOutput("rQueueDrained", rQ.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
